cache_port_arbiter: RTL and testbench
=====================================

Name: cache_port_arbiter

Overview:
- Shares the single CPU-side port of the 2-way set-associative cache (addr/read/write/w_data in; Done/r_data out) between two requesters: P0 (instruction fetch) and P1 (data load/store).
- Accepts one request at a time through a valid/ready handshake, arbitrates round-robin and holds the cache strobes stable until Done.
- Returns r_data to the winning requester with a one-cycle response pulse.
- A watchdog reports an error if the cache never raises Done.

Parameters:
- ADDRESS_WIDTH, 8, cache byte-address width.
- DATA_WIDTH, 32, data word width.
- TIMEOUT_CYCLES, 64, number of BUSY cycles without Done before abort; 0 disables the watchdog.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- p0_valid  in  1  P0 request pending.
- p0_ready  out  1  P0 request accepted at this edge when p0_valid=1.
- p0_we  in  1  1=write, 0=read.
- p0_addr  in  ADDRESS_WIDTH  P0 address.
- p0_wdata  in  DATA_WIDTH  P0 write data.
- p0_resp_valid  out  1  one-cycle P0 completion pulse.
- p0_resp_err  out  1  qualifies p0_resp_valid; 1=timeout.
- p1_valid, p1_ready, p1_we, p1_addr, p1_wdata, p1_resp_valid, p1_resp_err: identical to the P0 ports, for P1.
- resp_rdata  out  DATA_WIDTH  read data; valid with either resp_valid pulse.
- cache_addr  out  ADDRESS_WIDTH  to cache addr.
- cache_read  out  1  to cache read.
- cache_write  out  1  to cache write.
- cache_wdata  out  DATA_WIDTH  to cache w_data.
- cache_done  in  1  from cache Done.
- cache_rdata  in  DATA_WIDTH  from cache r_data.

Behaviour:
- Reset values (rst=1 at an edge): state=IDLE; all cache_* outputs=0; resp_rdata=0; all resp_valid/resp_err=0; timeout counter=0; last_grant=1 (P0 wins first tie).
- Reset mid-transaction aborts it silently: no response pulse; strobes drop at that edge.
- Three states: IDLE, BUSY, RESP.
- Arbitration is combinational, evaluated only in IDLE with cache_done=0:
  - Only one valid: grant it.
  - Both valid: grant the port not equal to last_grant.
  - pN_ready=1 only for the granted port; both readies are 0 in BUSY/RESP or while cache_done=1. This stale-Done guard is mandatory.
- IDLE -> BUSY on an accept edge:
  - Register cache_addr and cache_wdata from the granted port.
  - cache_write=we, cache_read=~we.
  - last_grant <= granted port; counter <= 0.
  - Strobes are visible from the cycle after the accept edge.
- BUSY, held every cycle:
  - Strobes, address and data do not change; requester inputs are ignored.
  - Counter increments each cycle in BUSY.
- BUSY, on an edge with cache_done=1:
  - Capture resp_rdata <= cache_rdata. On writes, capture whatever the cache drives.
  - Clear cache_read and cache_write; go to RESP.
  - Assert the owner's resp_valid=1 with resp_err=0.
- BUSY, watchdog expiry (TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with cache_done=0):
  - Clear strobes; resp_rdata <= 0; go to RESP with owner's resp_valid=1 and resp_err=1.
  - If Done and expiry coincide, Done wins (err=0).
- RESP (exactly one cycle):
  - resp_valid high for this cycle only; strobes low; then go to IDLE.
  - resp_rdata holds until the next completion.
- Minimum per-transaction overhead: accept -> BUSY ≥1 cycle -> RESP 1 cycle -> IDLE. The next accept is possible in the first IDLE cycle if cache_done=0.
- A requester may drop or change pN_valid before acceptance with no effect; after acceptance its inputs are don't-care.
- Width rules: addresses and data pass through unmodified. Counter width is clog2(TIMEOUT_CYCLES+1), minimum 1; it saturates and never wraps.

Test Plan:
1. Reset, then P0 reads 0x10 alone. Required:
   - p0_ready high for the accept cycle.
   - cache_read=1, cache_addr=0x10 until Done.
   - p0_resp_valid pulses once; resp_rdata equals the cache's r_data; p1_resp_valid stays 0.
2. P1 writes 0x90 with data 0xCAFEBABE. Required:
   - cache_write=1, cache_wdata=0xCAFEBABE throughout BUSY.
   - p1_resp_valid pulses with err=0.
   - A following P1 read of 0x90 returns 0xCAFEBABE.
3. P0 and P1 both assert valid continuously (P0 reads 0x30, P1 reads 0x70). Required:
   - Grant order P0, P1, P0, P1.
   - Each grant is followed by exactly one resp pulse on the matching port before the next grant.
4. Tie cache_done low with TIMEOUT_CYCLES=8, P0 reads 0x11. Required:
   - Strobes drop after 8 BUSY cycles.
   - p0_resp_valid=1, p0_resp_err=1, resp_rdata=0.
   - Arbiter returns to IDLE and accepts a P1 request next.
5. Hold cache_done=1 while in IDLE with p0_valid=1. Required: p0_ready=0 until cache_done falls, then accept on the next edge.
6. Assert rst during BUSY (P1 reading 0x70). Required: all outputs zero on the next cycle, no resp pulse, and P0 wins the first tie after reset.

Source files
------------

// File: rtl/cache_port_arbiter.sv
// Two-requester front end for the single CPU-side port of the cache.
// P0 (instruction fetch) and P1 (data load/store) present requests with a
// valid/ready handshake; one request at a time is accepted round-robin, the
// cache strobes are held stable until Done (or a watchdog timeout), and the
// owner receives a one-cycle response pulse with the read data.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pN_valid/ready            request handshake (N = 0, 1)
//   pN_we/addr/wdata          request payload
//   pN_resp_valid/resp_err    one-cycle completion pulse, err=1 on timeout
//   resp_rdata                read data, valid with either response pulse
//   cache_addr/read/write/wdata  strobes towards the cache
//   cache_done/rdata          completion and read data from the cache
module cache_port_arbiter #(
   parameter int unsigned ADDRESS_WIDTH  = 8,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     p0_valid,
   output logic                     p0_ready,
   input  logic                     p0_we,
   input  logic [ADDRESS_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0]    p0_wdata,
   output logic                     p0_resp_valid,
   output logic                     p0_resp_err,
   input  logic                     p1_valid,
   output logic                     p1_ready,
   input  logic                     p1_we,
   input  logic [ADDRESS_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0]    p1_wdata,
   output logic                     p1_resp_valid,
   output logic                     p1_resp_err,
   output logic [DATA_WIDTH-1:0]    resp_rdata,
   output logic [ADDRESS_WIDTH-1:0] cache_addr,
   output logic                     cache_read,
   output logic                     cache_write,
   output logic [DATA_WIDTH-1:0]    cache_wdata,
   input  logic                     cache_done,
   input  logic [DATA_WIDTH-1:0]    cache_rdata
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_EXP =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e                   state_q, state_d;
   logic                     last_grant_q, last_grant_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic                     read_q, read_d;
   logic                     write_q, write_d;
   logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
   logic                     p0_rv_q, p0_rv_d;
   logic                     p0_re_q, p0_re_d;
   logic                     p1_rv_q, p1_rv_d;
   logic                     p1_re_q, p1_re_d;

   logic                     grant_c;
   logic                     can_accept_c;

   // Round-robin grant; only meaningful in IDLE with no stale Done.
   always_comb begin
      grant_c = 1'b0;
      if (p0_valid && p1_valid) begin
         grant_c = ~last_grant_q;
      end else if (p1_valid) begin
         grant_c = 1'b1;
      end
      can_accept_c = (state_q == IDLE) && !cache_done;
      p0_ready     = can_accept_c && p0_valid && !grant_c;
      p1_ready     = can_accept_c && p1_valid && grant_c;
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      read_d       = read_q;
      write_d      = write_q;
      rdata_d      = rdata_q;
      p0_rv_d      = 1'b0;
      p0_re_d      = 1'b0;
      p1_rv_d      = 1'b0;
      p1_re_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (p0_ready || p1_ready) begin
               state_d      = BUSY;
               last_grant_d = grant_c;
               cnt_d        = '0;
               addr_d       = grant_c ? p1_addr  : p0_addr;
               wdata_d      = grant_c ? p1_wdata : p0_wdata;
               write_d      = grant_c ? p1_we    : p0_we;
               read_d       = grant_c ? ~p1_we   : ~p0_we;
            end
         end
         BUSY: begin
            // Saturating counter: never wraps back into the expiry window.
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (cache_done) begin
               state_d = RESP;
               rdata_d = cache_rdata;
               read_d  = 1'b0;
               write_d = 1'b0;
               p0_rv_d = ~last_grant_q;
               p1_rv_d = last_grant_q;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_EXP)) begin
               state_d = RESP;
               rdata_d = '0;
               read_d  = 1'b0;
               write_d = 1'b0;
               p0_rv_d = ~last_grant_q;
               p0_re_d = ~last_grant_q;
               p1_rv_d = last_grant_q;
               p1_re_d = last_grant_q;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         rdata_q      <= '0;
         p0_rv_q      <= 1'b0;
         p0_re_q      <= 1'b0;
         p1_rv_q      <= 1'b0;
         p1_re_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         read_q       <= read_d;
         write_q      <= write_d;
         rdata_q      <= rdata_d;
         p0_rv_q      <= p0_rv_d;
         p0_re_q      <= p0_re_d;
         p1_rv_q      <= p1_rv_d;
         p1_re_q      <= p1_re_d;
      end
   end

   assign cache_addr    = addr_q;
   assign cache_wdata   = wdata_q;
   assign cache_read    = read_q;
   assign cache_write   = write_q;
   assign resp_rdata    = rdata_q;
   assign p0_resp_valid = p0_rv_q;
   assign p0_resp_err   = p0_re_q;
   assign p1_resp_valid = p1_rv_q;
   assign p1_resp_err   = p1_re_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: behavioural cache model, transaction-level
// reference memory, and a scoreboard queue checked by a response monitor.
module tb_cache_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_valid, p0_ready, p0_we, p0_resp_valid, p0_resp_err;
   logic [7:0]  p0_addr;
   logic [31:0] p0_wdata;
   logic        p1_valid, p1_ready, p1_we, p1_resp_valid, p1_resp_err;
   logic [7:0]  p1_addr;
   logic [31:0] p1_wdata;
   logic [31:0] resp_rdata;
   logic [7:0]  cache_addr;
   logic        cache_read, cache_write;
   logic [31:0] cache_wdata;
   logic        cache_done;
   logic [31:0] cache_rdata;

   localparam logic [31:0] WR_RDATA = 32'h5A5A_5A5A;

   cache_port_arbiter #(
      .ADDRESS_WIDTH (8),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we),
      .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_resp_valid(p0_resp_valid), .p0_resp_err(p0_resp_err),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_resp_valid(p1_resp_valid), .p1_resp_err(p1_resp_err),
      .resp_rdata(resp_rdata),
      .cache_addr(cache_addr), .cache_read(cache_read), .cache_write(cache_write),
      .cache_wdata(cache_wdata), .cache_done(cache_done), .cache_rdata(cache_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          port;
      bit          err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] ref_mem[256];
   int          checks = 0;
   int          errors = 0;
   int          cache_mode = 0;  // 0 normal, 1 Done stuck low, 2 Done stuck high

   function automatic logic [31:0] init_word(input int i);
      return 32'h1234_5678 ^ (32'(i) * 32'h0101_0101);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected response of an accepted request, from the transaction view.
   task automatic push(input bit port, input bit we, input logic [7:0] addr,
                       input logic [31:0] wd);
      exp_t e;
      e.port = port;
      if (cache_mode == 1) begin
         e.err   = 1'b1;
         e.rdata = 32'h0;
      end else begin
         e.err = 1'b0;
         if (we) begin
            e.rdata       = WR_RDATA;
            ref_mem[addr] = wd;
         end else begin
            e.rdata = ref_mem[addr];
         end
      end
      exp_q.push_back(e);
   endtask

   // Cache model: random 1..4 cycle latency, one-cycle Done.
   initial begin
      logic [31:0] cmem[256];
      int lat;
      for (int i = 0; i < 256; i++) cmem[i] = init_word(i);
      cache_done  = 1'b0;
      cache_rdata = 32'h0;
      lat         = 0;
      forever begin
         @(negedge clk);
         if (cache_mode == 2) begin
            cache_done = 1'b1;
         end else if (cache_mode == 1) begin
            cache_done = 1'b0;
         end else if (cache_done) begin
            cache_done = 1'b0;
         end else if (cache_read || cache_write) begin
            if (lat == 0) begin
               cache_done  = 1'b1;
               cache_rdata = cache_write ? WR_RDATA : cmem[cache_addr];
               if (cache_write) cmem[cache_addr] = cache_wdata;
               lat = $urandom_range(0, 3);
            end else begin
               lat--;
            end
         end else begin
            lat = $urandom_range(0, 3);
         end
      end
   end

   // Response monitor: pops the scoreboard on every response pulse.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && (p0_resp_valid || p1_resp_valid)) begin
            chk("resp_single_port", 32'(p0_resp_valid & p1_resp_valid), 32'h0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL resp_unexpected: got p0=%0d p1=%0d expected no pulse",
                        p0_resp_valid, p1_resp_valid);
            end else begin
               e = exp_q.pop_front();
               chk("resp_port", 32'(p1_resp_valid), 32'(e.port));
               chk("resp_err", 32'(p1_resp_valid ? p1_resp_err : p0_resp_err), 32'(e.err));
               chk("resp_rdata", resp_rdata, e.rdata);
            end
         end
      end
   end

   // Present one request on a port, wait for acceptance, check strobes.
   task automatic issue(input bit port, input bit we, input logic [7:0] addr,
                        input logic [31:0] wd, output int tries);
      bit acc;
      acc   = 1'b0;
      tries = 0;
      @(negedge clk);
      if (port == 1'b0) begin
         p0_valid = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd;
      end else begin
         p1_valid = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd;
      end
      while (!acc && tries < 60) begin
         #4;
         if ((port == 1'b0 && p0_ready) || (port == 1'b1 && p1_ready)) begin
            acc = 1'b1;
            push(port, we, addr, wd);
            @(posedge clk);
            #1;
            p0_valid = 1'b0;
            p1_valid = 1'b0;
            chk("strobe_read", 32'(cache_read), 32'(!we));
            chk("strobe_write", 32'(cache_write), 32'(we));
            chk("strobe_addr", 32'(cache_addr), 32'(addr));
            if (we) chk("strobe_wdata", cache_wdata, wd);
         end else begin
            @(negedge clk);
            tries++;
         end
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: port %0d not accepted after %0d cycles", port, tries);
         p0_valid = 1'b0;
         p1_valid = 1'b0;
      end
   endtask

   // Both ports request continuously; grants must alternate starting at 'first'.
   task automatic dual(input int n, input bit first);
      bit want;
      int got, cyc;
      want = first;
      got  = 0;
      cyc  = 0;
      @(negedge clk);
      p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 8'h30;
      p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 8'h70;
      while (got < n && cyc < 300) begin
         #4;
         if (p0_ready || p1_ready) begin
            chk("tie_grant_port", 32'(p1_ready), 32'(want));
            chk("tie_one_ready", 32'(p0_ready & p1_ready), 32'h0);
            chk("tie_prev_resp_done", 32'(exp_q.size()), 32'h0);
            push(p1_ready, 1'b0, p1_ready ? 8'h70 : 8'h30, 32'h0);
            want = ~want;
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      p0_valid = 1'b0;
      p1_valid = 1'b0;
      if (got < n) begin
         checks++;
         errors++;
         $display("FAIL tie_grants: got %0d grants expected %0d", got, n);
      end
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 200) begin
         @(posedge clk);
         cyc++;
      end
      #2;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cache_read"}, 32'(cache_read), 32'h0);
      chk({tag, "_cache_write"}, 32'(cache_write), 32'h0);
      chk({tag, "_cache_addr"}, 32'(cache_addr), 32'h0);
      chk({tag, "_cache_wdata"}, cache_wdata, 32'h0);
      chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
      chk({tag, "_resp_pulses"},
          32'({p0_resp_valid, p0_resp_err, p1_resp_valid, p1_resp_err}), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not end, %0d errors so far", errors);
      $fatal(1, "global timeout");
   end

   initial begin
      int tries, busy;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      rst = 1'b1;
      p0_valid = 1'b0; p0_we = 1'b0; p0_addr = 8'h0; p0_wdata = 32'h0;
      p1_valid = 1'b0; p1_we = 1'b0; p1_addr = 8'h0; p1_wdata = 32'h0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      // 1: P0 read alone
      issue(1'b0, 1'b0, 8'h10, 32'h0, tries);
      drain();

      // 2: P1 write then read back
      issue(1'b1, 1'b1, 8'h90, 32'hCAFE_BABE, tries);
      issue(1'b1, 1'b0, 8'h90, 32'h0, tries);
      drain();

      // 3: continuous tie, last grant was P1
      dual(4, 1'b0);
      drain();

      // 4: watchdog, Done stuck low
      cache_mode = 1;
      issue(1'b0, 1'b0, 8'h11, 32'h0, tries);
      busy = 1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (!cache_read) break;
         busy++;
      end
      chk("timeout_busy_cycles", 32'(busy), 32'd8);
      drain();
      cache_mode = 0;
      issue(1'b1, 1'b0, 8'h22, 32'h0, tries);
      drain();

      // 5: stale Done in IDLE blocks acceptance
      cache_mode = 2;
      @(negedge clk);
      p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 8'h10;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #4;
         chk("ready_while_done", 32'(p0_ready), 32'h0);
      end
      cache_mode = 0;
      issue(1'b0, 1'b0, 8'h10, 32'h0, tries);
      chk("accept_after_done_falls", 32'(tries), 32'h0);
      drain();

      // 6: reset mid-transaction
      cache_mode = 1;
      issue(1'b1, 1'b0, 8'h70, 32'h0, tries);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      chk_all_zero("midreset");
      @(negedge clk);
      rst = 1'b0;
      cache_mode = 0;
      dual(1, 1'b0);
      drain();

      // Randomized traffic over a small address window
      for (int n = 0; n < 40; n++) begin
         issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               8'(8'h20 + $urandom_range(0, 7)), $urandom, tries);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
